fpbp_pass_sequencer: RTL and testbench

Datapath-side sequencer at the other end of the training controller's select/complete handshake. It receives the `select0` (convolution forward pass) and `select1` (FC backward pass) requests from the controller FSMs and walks the output index space of the requested pass, one position per cycle. It returns the one-cycle `FP_C_complete` / `BP_FC_complete` pulses that advance those FSMs.

---
 rtl/fpbp_pkg.sv | 22 ++
 rtl/pass_index_counter.sv | 38 +++
 rtl/fpbp_pass_sequencer.sv | 137 +++++++++++++
 tb/tb_fpbp_pass_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpbp_pkg.sv
// Shared types and helpers for the forward/backward pass sequencer.
package fpbp_pkg;

    // Sequencer state; also exported on the debug port of the top level.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_FC   = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    // Stride input bit to the actual stride value: 0 -> 1, 1 -> 2.
    function automatic int stride_decode(input logic s);
        return s ? 2 : 1;
    endfunction

    // Convolution output dimension with floor division.
    function automatic int od(input int img_w, input int ker, input int s);
        return (img_w - ker) / s + 1;
    endfunction

endpackage

// File: rtl/pass_index_counter.sv
// Row-major 2-D index counter. Limits are given as the last index of each
// dimension, so a single-row (1-D) walk uses row_max = 0.
module pass_index_counter #(
    parameter int ROW_W = 3,
    parameter int COL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [ROW_W-1:0] row_max,
    input  logic [COL_W-1:0] col_max,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    // Column advances every enabled cycle; wrapping it advances the row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (col == col_max) begin
                col <= '0;
                row <= (row == row_max) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign last = (row == row_max) && (col == col_max);

endmodule

// File: rtl/fpbp_pass_sequencer.sv
// Walks the output index space of a conv forward pass or an FC backward pass
// and returns a one-cycle completion pulse to the requesting controller FSM.
//
// Handshake: select0/select1 are level requests. A request seen in IDLE
// starts a pass; dropping it mid-pass aborts with no completion. When the
// pass finishes, FP_C_complete or BP_FC_complete pulses for exactly one cycle
// and the sequencer parks in WAIT until both selects are low, so a request
// that is still held after completion never starts a second pass.
module fpbp_pass_sequencer
    import fpbp_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int KER   = 3,
    parameter int FC_N  = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     select0,
    input  logic                     select1,
    input  logic                     stride,
    output logic                     FP_C_complete,
    output logic                     BP_FC_complete,
    output logic                     busy,
    output logic                     addr_valid,
    output logic [$clog2(IMG_W)-1:0] out_row,
    output logic [$clog2(IMG_W)-1:0] out_col,
    output logic [$clog2(FC_N)-1:0]  fc_idx,
    output logic [1:0]               dbg_state
);

    localparam int RW  = $clog2(IMG_W);
    localparam int FW  = $clog2(FC_N);
    localparam int CW  = (RW > FW) ? RW : FW;
    localparam int OD1 = od(IMG_W, KER, stride_decode(1'b0));
    localparam int OD2 = od(IMG_W, KER, stride_decode(1'b1));

    localparam logic [RW-1:0] OD1_ROW_MAX = RW'(OD1 - 1);
    localparam logic [RW-1:0] OD2_ROW_MAX = RW'(OD2 - 1);
    localparam logic [CW-1:0] OD1_COL_MAX = CW'(OD1 - 1);
    localparam logic [CW-1:0] OD2_COL_MAX = CW'(OD2 - 1);
    localparam logic [CW-1:0] FC_COL_MAX  = CW'(FC_N - 1);

    state_t          state, next_state;
    logic            stride_q;
    logic            cnt_clr, cnt_en, cnt_last;
    logic [RW-1:0]   row_max, cnt_row;
    logic [CW-1:0]   col_max, cnt_col;
    logic            fp_done_q, bp_done_q;

    // State register, stride latch and registered completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            stride_q  <= 1'b0;
            fp_done_q <= 1'b0;
            bp_done_q <= 1'b0;
        end else begin
            state     <= next_state;
            fp_done_q <= (state == ST_CONV) && (next_state == ST_WAIT);
            bp_done_q <= (state == ST_FC) && (next_state == ST_WAIT);
            if (state == ST_IDLE && select0) begin
                stride_q <= stride;
            end
        end
    end

    // Next-state decode plus counter limits and control.
    always_comb begin
        next_state = state;
        row_max    = stride_q ? OD2_ROW_MAX : OD1_ROW_MAX;
        col_max    = stride_q ? OD2_COL_MAX : OD1_COL_MAX;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (select0) begin
                    next_state = ST_CONV;
                end else if (select1) begin
                    next_state = ST_FC;
                end
            end
            ST_CONV: begin
                if (!select0) begin
                    next_state = ST_IDLE;
                end else if (cnt_last) begin
                    next_state = ST_WAIT;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_FC: begin
                row_max = '0;
                col_max = FC_COL_MAX;
                if (!select1) begin
                    next_state = ST_IDLE;
                end else if (cnt_last) begin
                    next_state = ST_WAIT;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!select0 && !select1) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    pass_index_counter #(
        .ROW_W (RW),
        .COL_W (CW)
    ) u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .row_max (row_max),
        .col_max (col_max),
        .row     (cnt_row),
        .col     (cnt_col),
        .last    (cnt_last)
    );

    // Outputs come straight from registers, gated by the registered state.
    assign busy           = (state == ST_CONV) || (state == ST_FC);
    assign addr_valid     = busy;
    assign out_row        = (state == ST_CONV) ? cnt_row : '0;
    assign out_col        = (state == ST_CONV) ? cnt_col[RW-1:0] : '0;
    assign fc_idx         = (state == ST_FC) ? cnt_col[FW-1:0] : '0;
    assign FP_C_complete  = fp_done_q;
    assign BP_FC_complete = bp_done_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_fpbp_pass_sequencer.sv
// Testbench for fpbp_pass_sequencer: scoreboard of expected positions plus
// per-scenario timing checks of the completion pulses.
module tb_fpbp_pass_sequencer;
    import fpbp_pkg::*;

    localparam int IMG_W = 8;
    localparam int KER   = 3;
    localparam int FC_N  = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       select0, select1, stride;
    logic       fp_c_complete, bp_fc_complete, busy, addr_valid;
    logic [2:0] out_row, out_col;
    logic [3:0] fc_idx;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    // Entry: {is_fc, row (or 0), col (or fc_idx)}
    logic [8:0] exp_q[$];
    logic [8:0] mon_obs, mon_exp;

    fpbp_pass_sequencer #(
        .IMG_W (IMG_W),
        .KER   (KER),
        .FC_N  (FC_N)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .select0        (select0),
        .select1        (select1),
        .stride         (stride),
        .FP_C_complete  (fp_c_complete),
        .BP_FC_complete (bp_fc_complete),
        .busy           (busy),
        .addr_valid     (addr_valid),
        .out_row        (out_row),
        .out_col        (out_col),
        .fc_idx         (fc_idx),
        .dbg_state      (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard: every valid position must match the head of exp_q.
    always @(negedge clk) begin
        if (rst_n && addr_valid) begin
            if (dbg_state == ST_FC) mon_obs = {1'b1, 4'd0, fc_idx};
            else                    mon_obs = {1'b0, 1'b0, out_row, 1'b0, out_col};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_position: got %h, required no valid position", mon_obs);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_obs !== mon_exp) begin
                    failures++;
                    $display("FAIL position: got %h, required %h", mon_obs, mon_exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_conv(input int odv, input int count);
        for (int i = 0; i < count; i++) begin
            exp_q.push_back({1'b0, 4'(i / odv), 4'(i % odv)});
        end
    endtask

    task automatic push_fc();
        for (int i = 0; i < FC_N; i++) begin
            exp_q.push_back({1'b1, 4'd0, 4'(i)});
        end
    endtask

    // Runs a fixed window of cycles, recording completion pulses; optionally
    // flips stride at cycle toggle_at. Observes only, never compares.
    task automatic wait_pass(input int window, input int toggle_at,
                             output int n_fp, output int n_bp,
                             output int first_cyc, output logic busy_at);
        n_fp = 0;
        n_bp = 0;
        first_cyc = -1;
        busy_at = 1'b1;
        for (int k = 1; k <= window; k++) begin
            step();
            if (k == toggle_at) stride = ~stride;
            if (fp_c_complete || bp_fc_complete) begin
                if (first_cyc < 0) begin
                    first_cyc = k;
                    busy_at = busy | addr_valid;
                end
                n_fp += int'(fp_c_complete);
                n_bp += int'(bp_fc_complete);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        select0 = 1'b0;
        select1 = 1'b0;
        stride = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (addr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b, required 0", addr_valid); end
        checks++; if ({fp_c_complete, bp_fc_complete} !== 2'b00) begin failures++; $display("FAIL reset_complete: got %b, required 00", {fp_c_complete, bp_fc_complete}); end
        checks++; if ({out_row, out_col, fc_idx} !== 10'd0) begin failures++; $display("FAIL reset_index: got %h, required 0", {out_row, out_col, fc_idx}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_conv_s1();
        int n_fp, n_bp, first;
        logic b;
        stride = 1'b0;
        select0 = 1'b1;
        push_conv(6, 36);
        wait_pass(45, 0, n_fp, n_bp, first, b);
        checks++; if (n_fp != 1) begin failures++; $display("FAIL conv_s1_pulses: got %0d, required 1", n_fp); end
        checks++; if (first != 37) begin failures++; $display("FAIL conv_s1_cycle: got %0d, required 37", first); end
        checks++; if (n_bp != 0) begin failures++; $display("FAIL conv_s1_bp: got %0d, required 0", n_bp); end
        checks++; if (b !== 1'b0) begin failures++; $display("FAIL conv_s1_busy_at_done: got %b, required 0", b); end
        checks++; if (dbg_state !== ST_WAIT) begin failures++; $display("FAIL conv_s1_held_wait: got %0d, required %0d", dbg_state, ST_WAIT); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL conv_s1_left: got %0d, required 0", exp_q.size()); end
        select0 = 1'b0;
        step();
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL conv_s1_release: got %0d, required %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_conv_s2();
        int n_fp, n_bp, first;
        logic b;
        stride = 1'b1;
        select0 = 1'b1;
        push_conv(3, 9);
        wait_pass(14, 4, n_fp, n_bp, first, b);
        checks++; if (n_fp != 1) begin failures++; $display("FAIL conv_s2_pulses: got %0d, required 1", n_fp); end
        checks++; if (first != 10) begin failures++; $display("FAIL conv_s2_cycle: got %0d, required 10", first); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL conv_s2_left: got %0d, required 0", exp_q.size()); end
        select0 = 1'b0;
        step();
    endtask

    task automatic test_fc();
        int n_fp, n_bp, first;
        logic b;
        select1 = 1'b1;
        push_fc();
        wait_pass(15, 0, n_fp, n_bp, first, b);
        checks++; if (n_bp != 1) begin failures++; $display("FAIL fc_pulses: got %0d, required 1", n_bp); end
        checks++; if (first != 11) begin failures++; $display("FAIL fc_cycle: got %0d, required 11", first); end
        checks++; if (n_fp != 0) begin failures++; $display("FAIL fc_fp_pulse: got %0d, required 0", n_fp); end
        checks++; if (b !== 1'b0) begin failures++; $display("FAIL fc_busy_at_done: got %b, required 0", b); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL fc_left: got %0d, required 0", exp_q.size()); end
        select1 = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int n_fp, n_bp, first;
        logic b;
        stride = 1'b0;
        select0 = 1'b1;
        select1 = 1'b1;
        push_conv(6, 36);
        wait_pass(40, 0, n_fp, n_bp, first, b);
        checks++; if (n_fp != 1 || n_bp != 0) begin failures++; $display("FAIL both_priority: got fp=%0d bp=%0d, required fp=1 bp=0", n_fp, n_bp); end
        checks++; if (first != 37) begin failures++; $display("FAIL both_cycle: got %0d, required 37", first); end
        select0 = 1'b0;
        select1 = 1'b0;
        step();
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL turnaround_idle: got %0d, required %0d", dbg_state, ST_IDLE); end
        select1 = 1'b1;
        push_fc();
        wait_pass(14, 0, n_fp, n_bp, first, b);
        checks++; if (n_bp != 1 || n_fp != 0) begin failures++; $display("FAIL b2b_fc_pulses: got fp=%0d bp=%0d, required fp=0 bp=1", n_fp, n_bp); end
        checks++; if (first != 11) begin failures++; $display("FAIL b2b_fc_cycle: got %0d, required 11", first); end
        select1 = 1'b0;
        step();
    endtask

    task automatic test_abort();
        int n_fp, n_bp, first;
        logic b;
        stride = 1'b0;
        select0 = 1'b1;
        push_conv(6, 21);
        wait_pass(21, 0, n_fp, n_bp, first, b);
        select0 = 1'b0;
        step();
        checks++; if (dbg_state !== ST_IDLE || busy !== 1'b0) begin failures++; $display("FAIL abort_idle: got state=%0d busy=%b, required state=0 busy=0", dbg_state, busy); end
        wait_pass(8, 0, n_fp, n_bp, first, b);
        checks++; if (n_fp != 0) begin failures++; $display("FAIL abort_no_pulse: got %0d, required 0", n_fp); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL abort_left: got %0d, required 0", exp_q.size()); end
        stride = 1'b1;
        select0 = 1'b1;
        push_conv(3, 9);
        wait_pass(14, 0, n_fp, n_bp, first, b);
        checks++; if (n_fp != 1 || first != 10) begin failures++; $display("FAIL abort_restart: got n=%0d cycle=%0d, required n=1 cycle=10", n_fp, first); end
        select0 = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        int n_fp, n_bp, first;
        logic b;
        select1 = 1'b1;
        push_fc();
        wait_pass(5, 0, n_fp, n_bp, first, b);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || addr_valid !== 1'b0) begin failures++; $display("FAIL areset_busy: got busy=%b valid=%b, required 0 0", busy, addr_valid); end
        checks++; if (fc_idx !== 4'd0) begin failures++; $display("FAIL areset_idx: got %0d, required 0", fc_idx); end
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL areset_state: got %0d, required %0d", dbg_state, ST_IDLE); end
        checks++; if (bp_fc_complete !== 1'b0) begin failures++; $display("FAIL areset_complete: got %b, required 0", bp_fc_complete); end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_fc();
        wait_pass(15, 0, n_fp, n_bp, first, b);
        checks++; if (n_bp != 1 || first != 11) begin failures++; $display("FAIL areset_restart: got n=%0d cycle=%0d, required n=1 cycle=11", n_bp, first); end
        select1 = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_conv_s1();
        test_conv_s2();
        test_fc();
        test_back_to_back();
        test_abort();
        test_async_reset();
        repeat (3) step();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL final_queue: got %0d, required 0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
